// File: rtl/uart_send_cache_if.sv
// Word-side and byte-side handshake bundle for uart_send_cache.
// slave = the serializer's view, master = the surrounding logic/transmitter's view.
interface uart_send_cache_if;
    logic [31:0] send_4bytes_data;
    logic        send_4bytes_en;
    logic        send_4bytes_ready;
    logic        send_4bytes_done;
    logic [7:0]  send_byte_data;
    logic        send_byte_en;
    logic        send_byte_busy;

    modport slave (
        input  send_4bytes_data, send_4bytes_en, send_byte_busy,
        output send_4bytes_ready, send_4bytes_done, send_byte_data, send_byte_en
    );

    modport master (
        output send_4bytes_data, send_4bytes_en, send_byte_busy,
        input  send_4bytes_ready, send_4bytes_done, send_byte_data, send_byte_en
    );
endinterface

// File: rtl/uart_send_cache.sv
// Serializes one 32-bit word into four bytes (MSB first) for the UART byte transmitter.
// Define SEND_CACHE_CHECKSUM_EN to append a fifth XOR-checksum byte.
module uart_send_cache #(
    parameter int BYTE_GAP      = 0,
    parameter int START_TIMEOUT = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    uart_send_cache_if.slave bus
);
`ifdef SEND_CACHE_CHECKSUM_EN
    localparam logic [2:0] LAST_IDX = 3'd4;
`else
    localparam logic [2:0] LAST_IDX = 3'd3;
`endif
    localparam logic [15:0] TIMEOUT_LIM = 16'(START_TIMEOUT);
    localparam logic [15:0] GAP_LIM     = 16'(BYTE_GAP);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT_HI, WAIT_LO, GAP, DONE} state_t;

    state_t      state_reg;
    logic [2:0]  idx_reg;
    logic [31:0] word_reg;
    logic [15:0] cnt_reg;
    logic        ready_reg;
    logic        done_reg;
    logic        byte_en_reg;
    logic [7:0]  byte_data_reg;

    logic [7:0]  word_bytes [4];
    logic [2:0]  idx_next;
    logic [15:0] cnt_next;
    logic [7:0]  byte_next;
    logic        last_byte;
    logic        byte_finished;

    for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
        assign word_bytes[gi] = word_reg[31 - 8*gi -: 8];
    end

    always_comb begin
        idx_next  = idx_reg + 3'd1;
        cnt_next  = cnt_reg + 16'd1;
        last_byte = (idx_reg == LAST_IDX);
        byte_next = word_bytes[idx_next[1:0]];
`ifdef SEND_CACHE_CHECKSUM_EN
        if (idx_next == 3'd4)
            byte_next = word_bytes[0] ^ word_bytes[1] ^ word_bytes[2] ^ word_bytes[3];
`endif
        // A byte is complete either when busy falls (no gap) or when the gap count expires.
        byte_finished = ((state_reg == WAIT_LO) && !bus.send_byte_busy && (BYTE_GAP == 0)) ||
                        ((state_reg == GAP) && (cnt_next == GAP_LIM));
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_reg     <= IDLE;
            idx_reg       <= 3'd0;
            word_reg      <= 32'd0;
            cnt_reg       <= 16'd0;
            ready_reg     <= 1'b1;
            done_reg      <= 1'b0;
            byte_en_reg   <= 1'b0;
            byte_data_reg <= 8'h00;
        end else begin
            byte_en_reg <= 1'b0;
            done_reg    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.send_4bytes_en) begin
                        word_reg      <= bus.send_4bytes_data;
                        idx_reg       <= 3'd0;
                        byte_data_reg <= bus.send_4bytes_data[31:24];
                        byte_en_reg   <= 1'b1;
                        ready_reg     <= 1'b0;
                        state_reg     <= LOAD;
                    end
                end
                LOAD: begin
                    cnt_reg   <= 16'd0;
                    state_reg <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (bus.send_byte_busy) begin
                        state_reg <= WAIT_LO;
                    end else if ((START_TIMEOUT != 0) && (cnt_next == TIMEOUT_LIM)) begin
                        // Transmitter never started: re-pulse the same byte.
                        byte_en_reg <= 1'b1;
                        state_reg   <= LOAD;
                    end else begin
                        cnt_reg <= cnt_next;
                    end
                end
                WAIT_LO: begin
                    if (!bus.send_byte_busy && (BYTE_GAP != 0)) begin
                        cnt_reg   <= 16'd0;
                        state_reg <= GAP;
                    end
                end
                GAP: cnt_reg <= cnt_next;
                DONE: begin
                    ready_reg <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase

            if (byte_finished) begin
                if (last_byte) begin
                    done_reg  <= 1'b1;
                    state_reg <= DONE;
                end else begin
                    idx_reg       <= idx_next;
                    byte_data_reg <= byte_next;
                    byte_en_reg   <= 1'b1;
                    state_reg     <= LOAD;
                end
            end
        end
    end

    assign bus.send_4bytes_ready = ready_reg;
    assign bus.send_4bytes_done  = done_reg;
    assign bus.send_byte_en      = byte_en_reg;
    assign bus.send_byte_data    = byte_data_reg;
endmodule

// File: tb/tb_uart_send_cache.sv
// Bench for uart_send_cache: dut0 uses default parameters, dut1 uses BYTE_GAP=3, START_TIMEOUT=4.
// Model transmitters raise busy one cycle after en for ten cycles; a scoreboard checks each byte.
module tb_uart_send_cache;
`ifdef SEND_CACHE_CHECKSUM_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    typedef struct packed {
        logic [31:0] word;
        logic [39:0] exp_bytes;   // b0,b1,b2,b3,checksum
    } vec_t;

    logic clk = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    logic drop1 = 1'b1;
    logic dropped1;
    int   bc0, bc1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    int        en_n0 = 0, en_n1 = 0, done_n0 = 0, done_n1 = 0, done_t0 = 0, done_t1 = 0;
    int        en_t0[$];
    int        en_t1[$];
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];

    uart_send_cache_if bus0 ();
    uart_send_cache_if bus1 ();

    uart_send_cache dut0 (.sys_clk(clk), .sys_rst(rst0), .bus(bus0));
    uart_send_cache #(.BYTE_GAP(3), .START_TIMEOUT(4)) dut1 (.sys_clk(clk), .sys_rst(rst1), .bus(bus1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model transmitters
    always @(posedge clk) begin
        if (rst0) begin
            bus0.send_byte_busy <= 1'b0;
            bc0 <= 0;
        end else if (bc0 != 0) begin
            bc0 <= bc0 - 1;
            bus0.send_byte_busy <= (bc0 != 1);
        end else if (bus0.send_byte_en) begin
            bus0.send_byte_busy <= 1'b1;
            bc0 <= 10;
        end
    end

    always @(posedge clk) begin
        if (rst1) begin
            bus1.send_byte_busy <= 1'b0;
            bc1 <= 0;
            dropped1 <= 1'b0;
        end else if (bc1 != 0) begin
            bc1 <= bc1 - 1;
            bus1.send_byte_busy <= (bc1 != 1);
        end else if (bus1.send_byte_en) begin
            if (drop1 && !dropped1) begin
                dropped1 <= 1'b1;
            end else begin
                bus1.send_byte_busy <= 1'b1;
                bc1 <= 10;
            end
        end
    end

    // Scoreboard monitors
    always @(negedge clk) begin
        if (bus0.send_byte_en) begin
            en_n0++;
            en_t0.push_back(cyc);
            if (exp_q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL d0_unexpected_byte: got %0h expected none", bus0.send_byte_data);
            end else begin
                chk("d0_byte_data", int'(bus0.send_byte_data), int'(exp_q0.pop_front()));
            end
        end
        if (bus0.send_4bytes_done) begin
            done_n0++;
            done_t0 = cyc;
        end
    end

    always @(negedge clk) begin
        if (bus1.send_byte_en) begin
            en_n1++;
            en_t1.push_back(cyc);
            if (exp_q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL d1_unexpected_byte: got %0h expected none", bus1.send_byte_data);
            end else begin
                chk("d1_byte_data", int'(bus1.send_byte_data), int'(exp_q1.pop_front()));
            end
        end
        if (bus1.send_4bytes_done) begin
            done_n1++;
            done_t1 = cyc;
        end
    end

    function automatic int rdy(input int d);
        return (d == 0) ? int'(bus0.send_4bytes_ready) : int'(bus1.send_4bytes_ready);
    endfunction
    function automatic int en_o(input int d);
        return (d == 0) ? int'(bus0.send_byte_en) : int'(bus1.send_byte_en);
    endfunction
    function automatic int en_cnt(input int d);
        return (d == 0) ? en_n0 : en_n1;
    endfunction
    function automatic int done_cnt(input int d);
        return (d == 0) ? done_n0 : done_n1;
    endfunction
    function automatic int done_time(input int d);
        return (d == 0) ? done_t0 : done_t1;
    endfunction
    function automatic int en_tsize(input int d);
        return (d == 0) ? en_t0.size() : en_t1.size();
    endfunction
    function automatic int en_time(input int d, input int i);
        return (d == 0) ? en_t0[i] : en_t1[i];
    endfunction
    function automatic int q_size(input int d);
        return (d == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_exp(input int d, input logic [7:0] b);
        if (d == 0) exp_q0.push_back(b);
        else        exp_q1.push_back(b);
    endtask

    task automatic push_vec(input int d, input vec_t v);
        for (int i = 0; i < NB; i++) push_exp(d, v.exp_bytes[39 - 8*i -: 8]);
    endtask

    task automatic clear_times(input int d);
        if (d == 0) en_t0.delete();
        else        en_t1.delete();
    endtask

    task automatic set_req(input int d, input logic en, input logic [31:0] data);
        if (d == 0) begin
            bus0.send_4bytes_en = en;
            bus0.send_4bytes_data = data;
        end else begin
            bus1.send_4bytes_en = en;
            bus1.send_4bytes_data = data;
        end
    endtask

    // Handshake one word, then scramble the data input to prove it was latched.
    task automatic start_word(input int d, input logic [31:0] w);
        chk("ready_before_accept", rdy(d), 1);
        set_req(d, 1'b1, w);
        tick();
        set_req(d, 1'b0, 32'h5A5A5A5A);
        chk("en_after_accept", en_o(d), 1);
        chk("ready_low_after_accept", rdy(d), 0);
    endtask

    task automatic wait_done(input int d, input int budget);
        int n0;
        int i;
        n0 = done_cnt(d);
        for (i = 0; i < budget; i++) begin
            tick();
            if (done_cnt(d) != n0) break;
        end
        if (i == budget) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
        end
    endtask

    task automatic finish_transfer(input int d, input int n_en, input int n_done,
                                   input int exp_en, input int skip, input int spacing);
        int last;
        chk("ready_low_at_done", rdy(d), 0);
        tick();
        chk("ready_after_done", rdy(d), 1);
        chk("done_pulses", done_cnt(d) - n_done, 1);
        chk("en_pulses", en_cnt(d) - n_en, exp_en);
        chk("scoreboard_empty", q_size(d), 0);
        for (int i = skip + 1; i < en_tsize(d); i++)
            chk("byte_spacing", en_time(d, i) - en_time(d, i - 1), spacing);
        last = en_tsize(d) - 1;
        if (last >= 0) chk("done_latency", done_time(d) - en_time(d, last), spacing);
    endtask

    task automatic run_word(input int d, input vec_t v, input int spacing);
        int n_en, n_done;
        push_vec(d, v);
        clear_times(d);
        n_en = en_cnt(d);
        n_done = done_cnt(d);
        start_word(d, v.word);
        wait_done(d, 300);
        finish_transfer(d, n_en, n_done, NB, 0, spacing);
    endtask

    vec_t vecs[6];
    vec_t va, vb;
    int   n_en, n_done, n_en2, t_d;

    initial begin
        vecs[0] = '{32'hA1B2C3D4, 40'hA1B2C3D404};
        vecs[1] = '{32'h00000000, 40'h0000000000};
        vecs[2] = '{32'hFFFFFFFF, 40'hFFFFFFFF00};
        vecs[3] = '{32'h12345678, 40'h1234567808};
        vecs[4] = '{32'h80000001, 40'h8000000181};
        vecs[5] = '{32'hDEADBEEF, 40'hDEADBEEF22};

        set_req(0, 1'b0, 32'h0);
        set_req(1, 1'b0, 32'h0);
        repeat (3) tick();
        chk("rst_ready", rdy(0), 1);
        chk("rst_done", int'(bus0.send_4bytes_done), 0);
        chk("rst_en", en_o(0), 0);
        chk("rst_data", int'(bus0.send_byte_data), 0);
        rst0 = 1'b0;
        rst1 = 1'b0;
        tick();

        for (int v = 0; v < 6; v++) run_word(0, vecs[v], 12);

        // Request held high with new data: ignored mid-transfer, taken at the next ready.
        va = vecs[3];
        vb = vecs[2];
        push_vec(0, va);
        push_vec(0, vb);
        clear_times(0);
        n_en = en_n0;
        n_done = done_n0;
        chk("hold_ready_before", rdy(0), 1);
        set_req(0, 1'b1, va.word);
        tick();
        set_req(0, 1'b1, vb.word);
        chk("hold_ready_low", rdy(0), 0);
        wait_done(0, 300);
        t_d = done_t0;
        tick();
        chk("hold_ready_high", rdy(0), 1);
        tick();
        chk("hold_second_en", en_o(0), 1);
        set_req(0, 1'b0, 32'h0);
        wait_done(0, 300);
        tick();
        chk("hold_en_pulses", en_n0 - n_en, 2 * NB);
        chk("hold_done_pulses", done_n0 - n_done, 2);
        chk("hold_scoreboard_empty", exp_q0.size(), 0);
        if (en_t0.size() > NB) chk("hold_second_start", en_t0[NB] - t_d, 2);

        // dut1: first en ignored by the transmitter, re-pulse after START_TIMEOUT+1.
        va = vecs[0];
        push_exp(1, 8'hA1);
        push_vec(1, va);
        clear_times(1);
        n_en = en_n1;
        n_done = done_n1;
        start_word(1, va.word);
        wait_done(1, 400);
        finish_transfer(1, n_en, n_done, NB + 1, 1, 15);
        if (en_t1.size() > 1) chk("timeout_repulse_delay", en_t1[1] - en_t1[0], 5);

        // dut1: BYTE_GAP=3 adds three idle cycles per byte and before done.
        run_word(1, vecs[3], 15);

        // Reset in the middle of the third byte.
        va = vecs[0];
        push_vec(0, va);
        n_en = en_n0;
        n_done = done_n0;
        start_word(0, va.word);
        for (int i = 0; i < 200 && (en_n0 - n_en) < 3; i++) tick();
        chk("abort_third_byte_started", en_n0 - n_en, 3);
        repeat (4) tick();
        rst0 = 1'b1;
        tick();
        chk("abort_ready", rdy(0), 1);
        chk("abort_en", en_o(0), 0);
        chk("abort_data", int'(bus0.send_byte_data), 0);
        chk("abort_done", int'(bus0.send_4bytes_done), 0);
        rst0 = 1'b0;
        exp_q0.delete();
        n_en2 = en_n0;
        repeat (40) tick();
        chk("abort_no_done", done_n0 - n_done, 0);
        chk("abort_no_en", en_n0 - n_en2, 0);
        run_word(0, vecs[5], 12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
